// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded control, operands and register
// indices, with hold (freeze), bubble and squash (flush) handling.
module id_exe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              bubble,
   input  logic              ID_valid,
   input  logic              ID_wb_en,
   input  logic              ID_mem_r_en,
   input  logic              ID_mem_w_en,
   input  logic              ID_b,
   input  logic              ID_s,
   input  logic [3:0]        ID_exe_cmd,
   input  logic [DATA_W-1:0] ID_pc,
   input  logic [DATA_W-1:0] ID_val_rn,
   input  logic [DATA_W-1:0] ID_val_rm,
   input  logic              ID_imm,
   input  logic [11:0]       ID_shift_operand,
   input  logic [23:0]       ID_signed_imm_24,
   input  logic [REG_W-1:0]  ID_dst,
   input  logic [REG_W-1:0]  ID_src1,
   input  logic [REG_W-1:0]  ID_src2,
   input  logic [3:0]        ID_status,
   output logic              EXE_valid,
   output logic              EXE_wb_en,
   output logic              EXE_mem_r_en,
   output logic              EXE_mem_w_en,
   output logic              EXE_b,
   output logic              EXE_s,
   output logic [3:0]        EXE_exe_cmd,
   output logic [DATA_W-1:0] EXE_pc,
   output logic [DATA_W-1:0] EXE_val_rn,
   output logic [DATA_W-1:0] EXE_val_rm,
   output logic              EXE_imm,
   output logic [11:0]       EXE_shift_operand,
   output logic [23:0]       EXE_signed_imm_24,
   output logic [REG_W-1:0]  EXE_dst,
   output logic [REG_W-1:0]  EXE_src1,
   output logic [REG_W-1:0]  EXE_src2,
   output logic [3:0]        EXE_status
);

   logic kill;
   assign kill = flush | bubble;

   // Control group: squashed to a no-op on flush or bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         EXE_valid    <= 1'b0;
         EXE_wb_en    <= 1'b0;
         EXE_mem_r_en <= 1'b0;
         EXE_mem_w_en <= 1'b0;
         EXE_b        <= 1'b0;
         EXE_s        <= 1'b0;
         EXE_exe_cmd  <= '0;
      end else if (!freeze) begin
         if (kill) begin
            EXE_valid    <= 1'b0;
            EXE_wb_en    <= 1'b0;
            EXE_mem_r_en <= 1'b0;
            EXE_mem_w_en <= 1'b0;
            EXE_b        <= 1'b0;
            EXE_s        <= 1'b0;
            EXE_exe_cmd  <= '0;
         end else begin
            EXE_valid    <= ID_valid;
            EXE_wb_en    <= ID_wb_en;
            EXE_mem_r_en <= ID_mem_r_en;
            EXE_mem_w_en <= ID_mem_w_en;
            EXE_b        <= ID_b;
            EXE_s        <= ID_s;
            EXE_exe_cmd  <= ID_exe_cmd;
         end
      end
   end

   // Data group: loads even on flush/bubble; only freeze holds it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         EXE_pc            <= '0;
         EXE_val_rn        <= '0;
         EXE_val_rm        <= '0;
         EXE_imm           <= 1'b0;
         EXE_shift_operand <= '0;
         EXE_signed_imm_24 <= '0;
         EXE_dst           <= '0;
         EXE_src1          <= '0;
         EXE_src2          <= '0;
         EXE_status        <= '0;
      end else if (!freeze) begin
         EXE_pc            <= ID_pc;
         EXE_val_rn        <= ID_val_rn;
         EXE_val_rm        <= ID_val_rm;
         EXE_imm           <= ID_imm;
         EXE_shift_operand <= ID_shift_operand;
         EXE_signed_imm_24 <= ID_signed_imm_24;
         EXE_dst           <= ID_dst;
         EXE_src1          <= ID_src1;
         EXE_src2          <= ID_src2;
         EXE_status        <= ID_status;
      end
   end

endmodule
